// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexing controller for an N_DIGITS common-anode seven-segment
// display. A double-buffered display word is walked one digit at a time. Each
// digit gets a BLANK gap, with all anodes off, followed by a SHOW window with
// its anode on. The nibble and the hex/BCD mode for the digit are presented to
// the external decoder from the start of its BLANK gap, so the decoder has
// settled before the anode lights.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   value        display word; digit k = value[4k+3:4k]
//   hex_in       1 = hex, 0 = BCD (staged with value)
//   dp_in        decimal-point enables, 1 = point on (staged with value)
//   lzb_en       leading-zero blanking enable (staged with value)
//   update       one-cycle strobe that stages value/hex_in/dp_in/lzb_en
//   digit_nibble nibble for the decoder
//   hex_trigger  mode for the decoder
//   AN           anodes, active low
//   DP           decimal-point cathode, active low
//   digit_idx    currently selected digit
//   frame_done   one-cycle pulse in the last SHOW cycle of digit N_DIGITS-1
//   pending      a staged update is waiting for the next frame boundary
module seg_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4*N_DIGITS-1:0]       value,
  input  logic                        hex_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  input  logic                        lzb_en,
  input  logic                        update,
  output logic [3:0]                  digit_nibble,
  output logic                        hex_trigger,
  output logic [N_DIGITS-1:0]         AN,
  output logic                        DP,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done,
  output logic                        pending
);

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  logic [0:0]            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [4*N_DIGITS-1:0] value_act_r, value_stg_r;
  logic                  hex_act_r, hex_stg_r;
  logic [N_DIGITS-1:0]   dp_act_r, dp_stg_r;
  logic                  lzb_act_r, lzb_stg_r;

  logic [0:0]            state_nxt_s;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [4*N_DIGITS-1:0] value_act_nxt_s;
  logic                  hex_act_nxt_s;
  logic [N_DIGITS-1:0]   dp_act_nxt_s;
  logic                  lzb_act_nxt_s;
  logic [N_DIGITS-1:0]   an_nxt_s;
  logic                  dp_nxt_s;
  logic                  load_digit_s;
  logic                  frame_done_nxt_s;

  // Selects the nibble of digit k from a display word.
  function automatic logic [3:0] nibble_at(input logic [4*N_DIGITS-1:0] v,
                                           input logic [IDX_W-1:0] k);
    return v[int'(k)*4 +: 4];
  endfunction

  // A digit is blanked when it and every more-significant digit are zero;
  // digit 0 always lights so a zero word still shows "0".
  function automatic logic is_suppressed(input logic [4*N_DIGITS-1:0] v,
                                         input logic lzb,
                                         input logic [IDX_W-1:0] k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((i >= int'(k)) && (v[i*4 +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    return lzb && (k != {IDX_W{1'b0}}) && upper_zero;
  endfunction

  // Scan FSM next-state: BLANK gap, SHOW window, advance digit.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CNT_W'(1);
    idx_nxt_s   = digit_idx;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_nxt_s = ST_SHOW;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = {CNT_W{1'b0}};
          idx_nxt_s   = (digit_idx == IDX_LAST) ? {IDX_W{1'b0}} : digit_idx + IDX_W'(1);
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_BLANK;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Active-buffer swap at the frame boundary; an update landing exactly on the
  // boundary bypasses staging so it is not delayed by a whole frame.
  always_comb begin
    value_act_nxt_s = value_act_r;
    hex_act_nxt_s   = hex_act_r;
    dp_act_nxt_s    = dp_act_r;
    lzb_act_nxt_s   = lzb_act_r;
    if (frame_done) begin
      if (update) begin
        value_act_nxt_s = value;
        hex_act_nxt_s   = hex_in;
        dp_act_nxt_s    = dp_in;
        lzb_act_nxt_s   = lzb_en;
      end else if (pending) begin
        value_act_nxt_s = value_stg_r;
        hex_act_nxt_s   = hex_stg_r;
        dp_act_nxt_s    = dp_stg_r;
        lzb_act_nxt_s   = lzb_stg_r;
      end else begin
        value_act_nxt_s = value_act_r;
      end
    end else begin
      value_act_nxt_s = value_act_r;
    end
  end

  // Output decode from next-cycle values so the registered outputs line up
  // with the state they describe.
  always_comb begin
    an_nxt_s = {N_DIGITS{1'b1}};
    dp_nxt_s = 1'b1;
    if ((state_nxt_s == ST_SHOW) &&
        !is_suppressed(value_act_nxt_s, lzb_act_nxt_s, idx_nxt_s)) begin
      an_nxt_s[idx_nxt_s] = 1'b0;
      dp_nxt_s            = ~dp_act_nxt_s[idx_nxt_s];
    end else begin
      dp_nxt_s = 1'b1;
    end
    load_digit_s     = (state_r == ST_SHOW) && (state_nxt_s == ST_BLANK);
    frame_done_nxt_s = (state_nxt_s == ST_SHOW) && (cnt_nxt_s == SHOW_LAST) &&
                       (idx_nxt_s == IDX_LAST);
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_BLANK;
      cnt_r        <= {CNT_W{1'b0}};
      digit_idx    <= {IDX_W{1'b0}};
      value_act_r  <= {(4*N_DIGITS){1'b0}};
      hex_act_r    <= 1'b0;
      dp_act_r     <= {N_DIGITS{1'b0}};
      lzb_act_r    <= 1'b0;
      value_stg_r  <= {(4*N_DIGITS){1'b0}};
      hex_stg_r    <= 1'b0;
      dp_stg_r     <= {N_DIGITS{1'b0}};
      lzb_stg_r    <= 1'b0;
      pending      <= 1'b0;
      AN           <= {N_DIGITS{1'b1}};
      DP           <= 1'b1;
      digit_nibble <= 4'h0;
      hex_trigger  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      digit_idx   <= idx_nxt_s;
      value_act_r <= value_act_nxt_s;
      hex_act_r   <= hex_act_nxt_s;
      dp_act_r    <= dp_act_nxt_s;
      lzb_act_r   <= lzb_act_nxt_s;
      if (update) begin
        value_stg_r <= value;
        hex_stg_r   <= hex_in;
        dp_stg_r    <= dp_in;
        lzb_stg_r   <= lzb_en;
      end
      if (frame_done) begin
        pending <= 1'b0;
      end else if (update) begin
        pending <= 1'b1;
      end
      AN         <= an_nxt_s;
      DP         <= dp_nxt_s;
      frame_done <= frame_done_nxt_s;
      if (load_digit_s) begin
        digit_nibble <= nibble_at(value_act_nxt_s, idx_nxt_s);
        hex_trigger  <= hex_act_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with N_DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=2.
// Digit slot = 6 cycles (2 BLANK + 4 SHOW), frame = 48 cycles counted from
// the first cycle after reset release. The stimulus pushes the expected
// appearance of each digit of a frame; the monitor pops one entry in the
// second SHOW cycle of every digit slot.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        hex_in;
  logic [7:0]  dp_in;
  logic        lzb_en;
  logic        update;
  logic [3:0]  digit_nibble;
  logic        hex_trigger;
  logic [7:0]  AN;
  logic        DP;
  logic [2:0]  digit_idx;
  logic        frame_done;
  logic        pending;

  seg_scan_ctrl #(.N_DIGITS(8), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .value(value), .hex_in(hex_in), .dp_in(dp_in),
    .lzb_en(lzb_en), .update(update), .digit_nibble(digit_nibble),
    .hex_trigger(hex_trigger), .AN(AN), .DP(DP), .digit_idx(digit_idx),
    .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [7:0] an;
    logic       dp;
    logic [3:0] nib;
    logic       hex;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Cycle index since the last reset release.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_digit(input int k, input bit lit, input bit dp_on,
                            input logic [3:0] nib, input bit hex);
    exp_t e;
    logic [7:0] one;
    one   = 8'h01;
    e.k   = k;
    e.an  = lit ? ~(one << k) : 8'hFF;
    e.dp  = (lit && dp_on) ? 1'b0 : 1'b1;
    e.nib = nib;
    e.hex = hex;
    exp_q.push_back(e);
  endtask

  // Monitor: blank gaps, frame_done timing, and one digit record per slot.
  always @(negedge clk) begin
    int f, k, p;
    exp_t e;
    if (!reset) begin
      f = cyc % 48;
      k = f / 6;
      p = f % 6;
      check("frame_done", {31'd0, frame_done}, {31'd0, (f == 47)});
      if (p < 2) begin
        check("blank_an", {24'd0, AN}, 32'h0000_00FF);
        check("blank_dp", {31'd0, DP}, 32'd1);
      end
      if (p == 3) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL slot_unexpected @cyc %0d: got digit %0d expected none", cyc, digit_idx);
        end else begin
          e = exp_q.pop_front();
          check("digit_idx", {29'd0, digit_idx}, e.k);
          check("show_an", {24'd0, AN}, {24'd0, e.an});
          check("show_dp", {31'd0, DP}, {31'd0, e.dp});
          check("nibble", {28'd0, digit_nibble}, {28'd0, e.nib});
          check("hex_trigger", {31'd0, hex_trigger}, {31'd0, e.hex});
        end
      end
    end
  end

  task automatic at_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reach_cycle", cyc, n);
  endtask

  task automatic upd(input logic [31:0] v, input logic hx, input logic [7:0] dp,
                     input logic lzb);
    value  = v;
    hex_in = hx;
    dp_in  = dp;
    lzb_en = lzb;
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_an"}, {24'd0, AN}, 32'h0000_00FF);
    check({tag, "_dp"}, {31'd0, DP}, 32'd1);
    check({tag, "_nib"}, {28'd0, digit_nibble}, 32'd0);
    check({tag, "_hex"}, {31'd0, hex_trigger}, 32'd0);
    check({tag, "_idx"}, {29'd0, digit_idx}, 32'd0);
    check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_pend"}, {31'd0, pending}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc_tab[6];
    logic [7:0]  an_tab[6];
    logic [3:0]  f2_nib[8];
    reset  = 1'b1;
    value  = 32'h0;
    hex_in = 1'b0;
    dp_in  = 8'h00;
    lzb_en = 1'b0;
    update = 1'b0;
    for (int k = 0; k < 8; k++) push_digit(k, 1'b1, 1'b0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");

    // Scenario 1: scan timing after reset.
    cyc_tab = '{1, 2, 5, 6, 8, 11};
    an_tab  = '{8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD};
    for (int i = 0; i < 6; i++) begin
      at_cyc(cyc_tab[i]);
      check("s1_an", {24'd0, AN}, {24'd0, an_tab[i]});
    end

    // Scenario 2: mid-frame hex update shows next frame.
    at_cyc(20);
    for (int k = 0; k < 8; k++) push_digit(k, 1'b1, 1'b0, 4'(15 - k), 1'b1);
    upd(32'h89AB_CDEF, 1'b1, 8'h00, 1'b0);
    check("s2_pend_set", {31'd0, pending}, 32'd1);
    at_cyc(47);
    check("s2_pend_hold", {31'd0, pending}, 32'd1);
    check("s2_fd", {31'd0, frame_done}, 32'd1);
    at_cyc(48);
    check("s2_pend_clr", {31'd0, pending}, 32'd0);
    check("s2_idx_wrap", {29'd0, digit_idx}, 32'd0);

    // Scenario 3: leading-zero blanking.
    at_cyc(60);
    f2_nib = '{4'h0, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int k = 0; k < 8; k++) push_digit(k, k < 3, 1'b0, f2_nib[k], 1'b0);
    upd(32'h0000_0120, 1'b0, 8'h00, 1'b1);
    at_cyc(100);
    for (int k = 0; k < 8; k++) push_digit(k, k == 0, 1'b0, 4'h0, 1'b0);
    upd(32'h0000_0000, 1'b0, 8'h00, 1'b1);

    // Scenario 4: last update wins; update on the frame_done cycle bypasses.
    at_cyc(150);
    upd(32'h1111_1111, 1'b0, 8'h00, 1'b0);
    at_cyc(160);
    for (int k = 0; k < 8; k++) push_digit(k, 1'b1, 1'b0, 4'h2, 1'b0);
    upd(32'h2222_2222, 1'b0, 8'h00, 1'b0);
    at_cyc(170);
    check("s4_pend", {31'd0, pending}, 32'd1);
    at_cyc(192);
    check("s4_pend_clr", {31'd0, pending}, 32'd0);
    at_cyc(239);
    check("s4_fd_cycle", {31'd0, frame_done}, 32'd1);
    for (int k = 0; k < 8; k++) push_digit(k, 1'b1, 1'b0, 4'(k), 1'b1);
    upd(32'h7654_3210, 1'b1, 8'h00, 1'b0);
    check("s4_bypass_pend", {31'd0, pending}, 32'd0);

    // Scenario 5: decimal point on digit 2 only, BCD mode.
    at_cyc(250);
    for (int k = 0; k < 8; k++) push_digit(k, 1'b1, k == 2, 4'(k), 1'b0);
    upd(32'h7654_3210, 1'b0, 8'b0000_0100, 1'b0);

    // Scenario 6: reset during digit 5 SHOW with an update pending.
    at_cyc(300);
    upd(32'hDEAD_BEEF, 1'b1, 8'hFF, 1'b0);
    at_cyc(310);
    check("s6_pend", {31'd0, pending}, 32'd1);
    at_cyc(322);
    check("s6_in_digit5", {29'd0, digit_idx}, 32'd5);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_reset_state("midreset");
    for (int k = 0; k < 8; k++) push_digit(k, 1'b1, 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    at_cyc(2);
    check("s6_restart_an", {24'd0, AN}, 32'h0000_00FE);
    at_cyc(8);
    check("s6_restart_an1", {24'd0, AN}, 32'h0000_00FD);
    at_cyc(50);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing controller for the 8-digit, common-anode seven-segment display on the calculator board. Holds a coherent 32-bit display word and walks the digits one at a time. For each digit it presents the nibble and the hex/BCD mode to the downstream seven-segment decoder (nibble in, active-low CA..CG out) and drives the matching active-low anode. A blanking gap between digits prevents ghosting. Display updates are double-buffered so each frame is tear-free.

Parameters:
N_DIGITS, 8, number of digits/anodes scanned; anode k shows nibble value[4k+3:4k].
REFRESH_DIV, 100000, clk cycles each digit is lit (1 ms at 100 MHz); minimum 2.
BLANK_CYCLES, 16, clk cycles all anodes are off between digits; minimum 1.

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
value  input  4*N_DIGITS  display word, digit 0 = least-significant nibble
hex_in  input  1  1 = hex representation, 0 = BCD; captured together with value
dp_in  input  N_DIGITS  decimal-point enables, 1 = point on
lzb_en  input  1  1 = leading-zero blanking on; captured together with value
update  input  1  one-cycle strobe: capture value/hex_in/dp_in/lzb_en
digit_nibble  output  4  nibble to decoder input
hex_trigger  output  1  mode to decoder hex_trigger
AN  output  N_DIGITS  anodes, active low
DP  output  1  decimal-point cathode, active low
digit_idx  output  $clog2(N_DIGITS)  index of the digit currently selected
frame_done  output  1  one-cycle pulse when digit N_DIGITS-1 finishes SHOW
pending  output  1  1 = staged update waiting for the next frame boundary

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values:
  - state = BLANK, cnt = 0, digit_idx = 0.
  - AN = all 1, DP = 1, digit_nibble = 0, hex_trigger = 0, frame_done = 0, pending = 0.
  - Active and staging registers are cleared: value 0, hex 0, dp 0, lzb 0.
- FSM, two states, one counter cnt:
  - BLANK: AN = all 1, DP = 1. When cnt == BLANK_CYCLES-1, go to SHOW and clear cnt; otherwise increment cnt.
  - SHOW: AN[digit_idx] = 0 unless the digit is suppressed, and every other AN bit = 1. DP = ~dp_active[digit_idx]. When cnt == REFRESH_DIV-1, go to BLANK, clear cnt, and set digit_idx = (digit_idx+1) mod N_DIGITS.
- Timing:
  - Per-digit period = REFRESH_DIV + BLANK_CYCLES cycles; frame = N_DIGITS times that.
  - After reset deassert, AN[0] goes low at cycle BLANK_CYCLES.
- Digit data: digit_nibble and hex_trigger are loaded on entry to BLANK for the new digit_idx (and by reset). They stay stable for the whole BLANK+SHOW window, so the decoder output settles before the anode turns on.
- Suppression: a digit is suppressed (AN stays 1, DP stays 1 during SHOW) when lzb_active = 1 and nibbles k..N_DIGITS-1 of value_active are all zero. Digit 0 is never suppressed.
- BCD mode: nibbles above 9 are passed through unchanged; blanking them is the decoder's responsibility.
- frame_done pulses in the cycle SHOW of digit N_DIGITS-1 ends, which is the same cycle digit_idx wraps to 0.
- Update handshake:
  - update = 1 loads the staging registers and sets pending = 1.
  - On the frame_done cycle with pending = 1, the active registers take the staging contents and pending clears.
  - update during an in-progress frame never changes the current frame's digits.
  - Back-to-back updates before a boundary: last one wins.
  - update in the frame_done cycle: the new inputs are bypassed straight into the active registers, and pending = 0 afterwards.
- Reset mid-frame: everything returns to reset values on the next edge and any staged update is discarded.

Test Plan:
1. N_DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=2. Release reset with no update -> AN=FF for cycles 0-1, AN=FE for cycles 2-5, digit_nibble=0, AN=FD at cycles 8-11, frame_done at cycle 47, digit_idx back to 0.
2. update with value=32'h89ABCDEF, hex_in=1, lzb_en=0 mid-frame -> pending=1 until frame_done; the next frame shows nibbles F,E,D,C,B,A,9,8 on digits 0..7 with hex_trigger=1; pending=0 afterwards.
3. value=32'h00000120, lzb_en=1 -> digits 3..7 keep AN bit 1 during their SHOW; digits 0,1,2 light with nibbles 0,2,1. value=0 with lzb_en=1 -> only digit 0 lights, showing 0.
4. Two updates in one frame (32'h11111111, then 32'h22222222) -> next frame shows all 2s. An update exactly on the frame_done cycle -> applied in the immediately following frame, pending=0.
5. dp_in=8'b00000100, hex_in=0 -> DP=0 only during digit 2's SHOW and 1 everywhere else, including BLANK; hex_trigger=0 throughout.
6. Assert reset during digit 5's SHOW with pending=1 -> next cycle AN=FF, digit_idx=0, pending=0, active value=0; the scan restarts as in scenario 1.
